// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one
// input bit per clock. Feeds the per-digit seven-segment decoders; the bcd
// result is held stable between conversions so the display never flickers.
//
// Parameters:
//   BIN_WIDTH  width of the binary input (1..32)
//   DIGITS     number of packed BCD digits produced (1..8)
//
// Ports:
//   clock      rising-edge clock
//   reset_L    asynchronous active-low reset
//   in_valid   upstream presents a value on bin
//   in_ready   converter idle, value on bin is accepted when in_valid=1
//   bin        unsigned binary input, sampled only on accept
//   out_valid  bcd holds a fresh, unconsumed result
//   out_ready  downstream consumes the result
//   bcd        packed BCD, digit k in bcd[4k+3:4k] (digit 0 = ones)
//   overflow   last result saturated
//
// Optional feature macro: BCD_SATURATE_EN
//   defined   -> inputs above 10^DIGITS-1 produce all-9 digits and overflow=1
//   undefined -> no comparator, overflow tied low, bcd = bin mod 10^DIGITS
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]   bin_sr_q, bin_sr_d;
  logic [W-1:0]           work_q, work_d;
  logic [W-1:0]           bcd_q, bcd_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           adj_s;
  logic [W-1:0]           shifted_s;

`ifdef BCD_SATURATE_EN
  logic                   pend_q, pend_d;
  logic                   ovf_q, ovf_d;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;
`endif

  // Add-3 correction on every digit >= 5, then the one-bit left shift.
  always_comb begin
    adj_s = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj_s[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end else begin
        adj_s[4*k +: 4] = work_q[4*k +: 4];
      end
    end
    // Carry out of the top digit falls off the end: result is mod 10^DIGITS.
    shifted_s = {adj_s[W-2:0], bin_sr_q[BIN_WIDTH-1]};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_sr_d    = bin_sr_q;
    work_d      = work_q;
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
`ifdef BCD_SATURATE_EN
    pend_d      = pend_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = SHIFT;
          bin_sr_d = bin;
          work_d   = {W{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
`ifdef BCD_SATURATE_EN
          pend_d   = (64'(bin) > MAX_DEC);
`endif
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        work_d   = shifted_s;
        bin_sr_d = bin_sr_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final shift: publish the freshly shifted work value directly.
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef BCD_SATURATE_EN
          if (pend_q) begin
            bcd_d = {DIGITS{4'h9}};
          end else begin
            bcd_d = shifted_s;
          end
          ovf_d = pend_q;
`else
          bcd_d = shifted_s;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bin_sr_q    <= {BIN_WIDTH{1'b0}};
      work_q      <= {W{1'b0}};
      bcd_q       <= {W{1'b0}};
      out_valid_q <= 1'b0;
`ifdef BCD_SATURATE_EN
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_sr_q    <= bin_sr_d;
      work_q      <= work_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
`ifdef BCD_SATURATE_EN
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
`ifdef BCD_SATURATE_EN
  assign overflow  = ovf_q;
`else
  assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_converter
//
// Scoreboard bench for bin_to_bcd_converter (BIN_WIDTH=14, DIGITS=4).
// The stimulus process pushes hand-computed expected results when it issues a
// value; an independent monitor pops and compares on each output handshake,
// and also checks latency, stall stability and the one-cycle DONE return.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_converter;

  logic        clock;
  logic        reset_L;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bcd;
  logic        overflow;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   stall_cnt = 0;
  bit   chk_idle  = 1'b0;
  bit   ov_prev   = 1'b0;

  bin_to_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .overflow  (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter: value equals number of rising edges seen so far.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present v until accepted; acc returns the cycle number of the accept edge.
  task automatic send(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                      input bit track, output int acc);
    int   guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    bin      = v;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      acc      = -1;
    end else begin
      acc = cyc + 1;
      if (track) begin
        e.bcd = eb;
        e.ovf = eo;
        e.acc = acc;
        q.push_back(e);
      end
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("drain", 32'(q.size()), 32'd0);
    tick();
    tick();
  endtask

  // Monitor: samples on the falling edge, pops and compares on handshakes.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_L) begin
        if (chk_idle) begin
          check("done_one_cycle_out_valid", 32'(out_valid), 32'd0);
          check("in_ready_back", 32'(in_ready), 32'd1);
          chk_idle = 1'b0;
        end
        if (out_valid && !ov_prev) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            check("latency", 32'(cyc - q[0].acc), 32'd14);
          end
        end
        if (out_valid && !out_ready) begin
          stall_cnt++;
          if (q.size() != 0) begin
            check("stall_bcd_stable", 32'(bcd), 32'(q[0].bcd));
          end else begin
            check("stall_without_expect", 32'(out_valid), 32'd0);
          end
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_handshake", 32'(out_valid), 32'd0);
          end else begin
            check("bcd", 32'(bcd), 32'(q[0].bcd));
            check("overflow", 32'(overflow), 32'(q[0].ovf));
            void'(q.pop_front());
            chk_idle = 1'b1;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    int guard;
    int seen;
    logic [15:0] sat_bcd;
    logic        sat_ovf;

    reset_L   = 1'b0;
    in_valid  = 1'b0;
    bin       = 14'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset_L = 1'b1;
    tick();

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0000);
    check("rst_overflow", 32'(overflow), 32'd0);

    // 1234 with downstream always ready.
    send(14'd1234, 16'h1234, 1'b0, 1'b1, a0);
    wait_drain();

    // 0 then 9999 back to back; accepts must be 16 cycles apart.
    send(14'd0, 16'h0000, 1'b0, 1'b1, a0);
    send(14'd9999, 16'h9999, 1'b0, 1'b1, a1);
    check("accept_spacing", 32'(a1 - a0), 32'd16);
    wait_drain();

    // 507 with a 5-cycle stall; in_valid pulses during the stall are ignored.
    out_ready = 1'b0;
    stall_cnt = 0;
    send(14'd507, 16'h0507, 1'b0, 1'b1, a0);
    guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    check("stall_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      bin      = 14'd42;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("stall_cycles", 32'(stall_cnt), 32'd5);

    // 12345 exceeds four digits.
`ifdef BCD_SATURATE_EN
    sat_bcd = 16'h9999;
    sat_ovf = 1'b1;
`else
    sat_bcd = 16'h2345;
    sat_ovf = 1'b0;
`endif
    send(14'd12345, sat_bcd, sat_ovf, 1'b1, a0);
    wait_drain();

    // Reset mid-SHIFT: in-flight value is discarded, outputs clear at once.
    send(14'd4321, 16'h4321, 1'b0, 1'b0, a0);
    repeat (5) tick();
    reset_L = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_bcd", 32'(bcd), 32'h0000);
    check("abort_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    reset_L = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_idle", 32'(in_ready), 32'd1);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
